main_mem_ctrl: RTL
==================

# main_mem_ctrl

Main-memory side of the cache: a word-addressed backing store with a programmable wait-state counter. It accepts single-word read or write requests from the cache controller FSM (`MStrobe`/`MRW`) and holds the access for `LATENCY` cycles. It then raises the one-cycle `CtrSig` completion pulse that the controller waits on in its ReadMem/WriteMem states. It also supplies the read word that the cache data array loads when `Wsel` selects memory data.

## Interface
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 10: word-address width; depth is 2**`ADDR_W`.
- `LATENCY`, default 4: cycles from accepted strobe to `CtrSig`. Legal range is ≥1; elaboration fails for values below 1.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `LdCtr`  in  1  1 = hold/reload wait counter to `LATENCY`-1; 0 = count down.
- `MStrobe`  in  1  request strobe, sampled only when idle.
- `MRW`  in  1  1 = write, 0 = read; sampled with `MStrobe` only.
- `MAddr`  in  `ADDR_W`  word address, sampled with `MStrobe`.
- `MDataIn`  in  `DATA_W`  write data, sampled with `MStrobe`.
- `MDataOut`  out  `DATA_W`  read data, registered.
- `CtrSig`  out  1  access-complete pulse, one cycle.
- `MBusy`  out  1  1 while a request is outstanding.

## Operation
- Storage: array of 2**`ADDR_W` × `DATA_W`. It is not cleared by reset; contents are undefined until written.
- Request latches: `addr_q`, `data_q`, `rw_q`.
- Wait counter: `cnt`, width clog2(`LATENCY`)+1 bits, unsigned. It never decrements below 0.
- States: IDLE, WAIT.
- IDLE with `MStrobe`=1:
  - capture `MAddr`/`MDataIn`/`MRW`;
  - `cnt` <= `LATENCY`-1;
  - go to WAIT;
  - if `MRW`=0, `MDataOut` <= mem[`MAddr`] on this same edge.
- IDLE with `MStrobe`=0: hold all state.
- WAIT with `LdCtr`=1: `cnt` <= `LATENCY`-1 (restart wait); `CtrSig`=0.
- WAIT with `LdCtr`=0 and `cnt`≠0: `cnt` <= `cnt`-1.
- WAIT with `LdCtr`=0 and `cnt`=0:
  - `CtrSig`=1 (combinational from state/`cnt`/`LdCtr`);
  - on this edge, if `rw_q`=1, mem[`addr_q`] <= `data_q`;
  - go to IDLE.
- `MBusy` = (state == WAIT).
- `MStrobe` is ignored while in WAIT, including the `CtrSig` cycle. The controller must re-strobe from IDLE.
- `MDataOut` changes only on an accepted read. It holds its value across writes and idle cycles until the next accepted read.
- Write commit is the only array update. A read issued to the same address on the cycle after a write's `CtrSig` returns the new data.
- Reset (any state, including mid-WAIT):
  - state goes to IDLE;
  - `cnt` = `LATENCY`-1;
  - `CtrSig`=0, `MBusy`=0, `MDataOut`=0;
  - a pending write is discarded and the array is untouched.

## Timing
- Strobe accepted at edge T (IDLE, `MStrobe`=1). With `LdCtr` low from T+1 onward, `CtrSig`=1 during cycle T+`LATENCY` and 0 at T+`LATENCY`+1.
- Each cycle `LdCtr`=1 is held in WAIT extends completion by one cycle, plus the remaining count restarted.
- With `LATENCY`=1, `CtrSig` is high in the first WAIT cycle when `LdCtr`=0.
- Read data is stable from T+1 through at least the cycle after `CtrSig`. The controller's ReadData state samples it there.
- `LdCtr` held at 1 while in IDLE has no effect.

## Test plan
- Read latency: after reset, preload mem[5]=0xDEADBEEF via write. Then strobe read at addr 5 with `LdCtr`=0 from the next cycle -> `MBusy` high 4 cycles, `CtrSig` high exactly at cycle T+4, `MDataOut`=0xDEADBEEF.
- Write-then-read: write 0x12345678 to addr 0x3FF, wait for `CtrSig`, then read addr 0x3FF -> `MDataOut`=0x12345678. A read of addr 0 still returns its prior value.
- Counter reload: read strobe, then hold `LdCtr`=1 for 3 WAIT cycles, then release -> `CtrSig` at T+3+4 = T+7, single cycle wide.
- Busy rejection: assert `MStrobe` with write to addr 9 during WAIT and during the `CtrSig` cycle -> mem[9] unchanged, no second `CtrSig`, `MBusy` drops the cycle after `CtrSig`.
- Reset mid-write: strobe write 0xAAAA_5555 to addr 7 (mem[7]=0x1), assert `reset` at T+2 -> `MBusy`=0, `CtrSig`=0, `MDataOut`=0 next cycle; later read of addr 7 returns 0x1.
- `LATENCY`=1 build: read strobe with `LdCtr`=0 -> `CtrSig` at T+1, back to IDLE at T+2, back-to-back strobe at T+2 accepted.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: word-addressed backing store behind the cache controller.
// One read or write request is accepted from IDLE and held in WAIT for
// LATENCY cycles. CtrSig then pulses for one cycle, and on that edge a
// pending write is committed to the array. Read data is fetched when the
// request is accepted and stays on MDataOut until the next accepted read.
module main_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LdCtr,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              CtrSig,
  output logic              MBusy
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LATENCY - 1);

  // A zero or negative wait count has no meaningful completion point.
  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("main_mem_ctrl: LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                rw_q;
  logic                done;

  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  // Completion is the last WAIT cycle with the reload input released.
  // A reset in that cycle suppresses the pulse and the write commit.
  assign done   = (state == ST_WAIT) && !LdCtr && (cnt == '0) && !reset;
  assign CtrSig = done;
  assign MBusy  = (state == ST_WAIT);

  // Request FSM: latches the request, counts wait states, returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= RELOAD;
      MDataOut <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rw_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MStrobe) begin
            addr_q <= MAddr;
            data_q <= MDataIn;
            rw_q   <= MRW;
            cnt    <= RELOAD;
            state  <= ST_WAIT;
            if (!MRW) begin
              MDataOut <= mem[MAddr];
            end
          end
        end
        ST_WAIT: begin
          if (LdCtr) begin
            cnt <= RELOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array update: the only write path, taken on the completion edge.
  always_ff @(posedge clk) begin
    if (done && rw_q) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule
